store_buffer: RTL and testbench

Data-side store buffer between the single-cycle MIPS core's memory port (memwrite / aluout / writedata / readdata) and the data memory. It queues core stores and drains them to memory through a req/ack write handshake, so slow memory writes do not stretch the core cycle. Loads are served combinationally: the youngest matching buffered store is forwarded, otherwise the memory read data is returned. It lives in the processor top level, directly downstream of the core.

---
 rtl/store_buffer_pkg.sv | 24 ++
 rtl/store_buffer_match.sv | 28 ++
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the data-side store buffer: occupancy encoding,
// word-address geometry and the count-width rule.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Byte-offset bits dropped from every address before it is stored or compared.
  localparam int WORD_LSB = 2;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic occ_e occ_state(input logic is_zero, input logic is_full);
    if (is_zero) return OCC_EMPTY;
    if (is_full) return OCC_FULL;
    return OCC_PARTIAL;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Load-forwarding lookup: DEPTH-way word-address compare with age priority,
// so the youngest valid entry (closest to tail) wins.
module sb_match #(
  parameter int DEPTH = 4,
  parameter int WAW   = 30,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WAW-1:0] ent_addr_i,
  input  logic [DEPTH-1:0]          ent_vld_i,
  input  logic [PW-1:0]             head_i,
  input  logic [WAW-1:0]            lkup_addr_i,
  output logic                      hit_o,
  output logic [PW-1:0]             sel_o
);

  // Walk from oldest (head) to youngest; a later match overrides an earlier one.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld_i[head_i + PW'(k)] && (ent_addr_i[head_i + PW'(k)] == lkup_addr_i)) begin
        hit_o = 1'b1;
        sel_o = head_i + PW'(k);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the core memory port and data memory: queues stores,
// drains them over a req/ack handshake and forwards buffered data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_we,
  input  logic [AW-1:0]           cpu_addr,
  input  logic [DW-1:0]           cpu_wdata,
  output logic [DW-1:0]           cpu_rdata,
  output logic                    stall,
  output logic [AW-1:0]           mem_raddr,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    mem_wreq,
  output logic [AW-1:0]           mem_waddr,
  output logic [DW-1:0]           mem_wdata,
  input  logic                    mem_wack,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = cnt_width(DEPTH);
  localparam int WAW = AW - WORD_LSB;

  logic [WAW-1:0] addr_q [DEPTH];
  logic [DW-1:0]  data_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop;
  occ_e occ;

  logic [DEPTH-1:0][WAW-1:0] ent_addr;
  logic [DEPTH-1:0]          ent_vld;
  logic                      hit;
  logic [PW-1:0]             sel;

  assign occ = occ_state(count_q == '0, count_q == CW'(DEPTH));

  // Stall depends only on occupancy, never on mem_wack, to keep the memory
  // acknowledge off the core's critical path.
  assign stall    = cpu_we & (occ == OCC_FULL);
  assign push     = cpu_we & (occ != OCC_FULL);
  assign mem_wreq = (occ != OCC_EMPTY);
  assign pop      = mem_wreq & mem_wack;
  assign empty    = (occ == OCC_EMPTY);
  assign count    = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; validity comes from head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr[AW-1:WORD_LSB];
      data_q[tail_q] <= cpu_wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i] = addr_q[i];
      ent_vld[i]  = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW),
    .PW    (PW)
  ) u_match (
    .ent_addr_i  (ent_addr),
    .ent_vld_i   (ent_vld),
    .head_i      (head_q),
    .lkup_addr_i (cpu_addr[AW-1:WORD_LSB]),
    .hit_o       (hit),
    .sel_o       (sel)
  );

  assign mem_raddr = cpu_addr;
  assign cpu_rdata = hit ? data_q[sel] : mem_rdata;

  // Head fields are masked while empty so stale storage never reaches the bus.
  assign mem_waddr = mem_wreq ? {addr_q[head_q], {WORD_LSB{1'b0}}} : '0;
  assign mem_wdata = mem_wreq ? data_q[head_q] : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, forwarding, ordering, full/stall,
// back-to-back drain with pointer wrap, and ack-while-empty.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wreq;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wack;
  logic        empty;
  logic [2:0]  count;

  int checks = 0;
  int passed = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  localparam logic [31:0] MEMV = 32'hCAFEF00D;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .mem_wreq  (mem_wreq),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wack  (mem_wack),
    .empty     (empty),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one clock; records a memory write if the handshake completes at this edge.
  task automatic tick();
    #1;
    if (reset && mem_wreq && mem_wack) begin
      log_addr.push_back(mem_waddr);
      log_data.push_back(mem_wdata);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; mem_wack = 1'b0;
    mem_rdata = MEMV;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (count !== 3'd0) $display("FAIL reset_count act=%0d exp=0", count); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty act=%b exp=1", empty); else passed++;
    checks++; if (mem_wreq !== 1'b0) $display("FAIL reset_wreq act=%b exp=0", mem_wreq); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall act=%b exp=0", stall); else passed++;
    checks++; if (mem_waddr !== 32'h0) $display("FAIL reset_waddr act=%h exp=0", mem_waddr); else passed++;
    checks++; if (mem_wdata !== 32'h0) $display("FAIL reset_wdata act=%h exp=0", mem_wdata); else passed++;
    checks++; if (cpu_rdata !== MEMV) $display("FAIL reset_rdata act=%h exp=%h", cpu_rdata, MEMV); else passed++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    mem_wack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h300 + 32'(4 * i); cpu_wdata = 32'(i + 1);
      tick();
    end
    cpu_we = 1'b0; cpu_addr = 32'h300; #1;
    checks++; if (count !== 3'd3) $display("FAIL mid_count_pre act=%0d exp=3", count); else passed++;
    checks++; if (cpu_rdata !== 32'h1) $display("FAIL mid_fwd_pre act=%h exp=1", cpu_rdata); else passed++;
    reset = 1'b0; #1;
    checks++; if (mem_wreq !== 1'b0) $display("FAIL mid_wreq act=%b exp=0", mem_wreq); else passed++;
    checks++; if (count !== 3'd0) $display("FAIL mid_count act=%0d exp=0", count); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL mid_empty act=%b exp=1", empty); else passed++;
    checks++; if (cpu_rdata !== MEMV) $display("FAIL mid_rdata act=%h exp=%h", cpu_rdata, MEMV); else passed++;
    tick();
    reset = 1'b1;
    tick();
    #1;
    checks++; if (cpu_rdata !== MEMV) $display("FAIL mid_rdata_post act=%h exp=%h", cpu_rdata, MEMV); else passed++;
  endtask

  task automatic test_single_store();
    log_addr.delete(); log_data.delete();
    mem_wack = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF; #1;
    checks++; if (mem_wreq !== 1'b0) $display("FAIL single_wreq_early act=%b exp=0", mem_wreq); else passed++;
    checks++; if (cpu_rdata !== MEMV) $display("FAIL single_fwd_early act=%h exp=%h", cpu_rdata, MEMV); else passed++;
    tick();
    cpu_we = 1'b0; #1;
    checks++; if (mem_wreq !== 1'b1) $display("FAIL single_wreq act=%b exp=1", mem_wreq); else passed++;
    checks++; if (mem_waddr !== 32'h100) $display("FAIL single_waddr act=%h exp=100", mem_waddr); else passed++;
    checks++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL single_wdata act=%h exp=deadbeef", mem_wdata); else passed++;
    cpu_addr = 32'h102; #1;
    checks++; if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL single_fwd_102 act=%h exp=deadbeef", cpu_rdata); else passed++;
    cpu_addr = 32'h104; #1;
    checks++; if (cpu_rdata !== MEMV) $display("FAIL single_fwd_104 act=%h exp=%h", cpu_rdata, MEMV); else passed++;
    mem_wack = 1'b1;
    tick();
    mem_wack = 1'b0; #1;
    checks++; if (count !== 3'd0) $display("FAIL single_count_drained act=%0d exp=0", count); else passed++;
    checks++; if (log_data.size() != 1 || log_data[0] !== 32'hDEADBEEF)
      $display("FAIL single_mem_write act_n=%0d exp_n=1", log_data.size()); else passed++;
  endtask

  task automatic test_same_word();
    log_addr.delete(); log_data.delete();
    mem_wack = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h1; tick();
    cpu_wdata = 32'h2; tick();
    cpu_we = 1'b0; #1;
    checks++; if (count !== 3'd2) $display("FAIL same_count act=%0d exp=2", count); else passed++;
    checks++; if (cpu_rdata !== 32'h2) $display("FAIL same_youngest act=%h exp=2", cpu_rdata); else passed++;
    mem_wack = 1'b1;
    tick(); tick();
    mem_wack = 1'b0; #1;
    checks++; if (log_data.size() != 2) $display("FAIL same_nwrites act=%0d exp=2", log_data.size()); else passed++;
    if (log_data.size() == 2) begin
      checks++; if (log_data[0] !== 32'h1 || log_addr[0] !== 32'h200)
        $display("FAIL same_first act=%h@%h exp=1@200", log_data[0], log_addr[0]); else passed++;
      checks++; if (log_data[1] !== 32'h2 || log_addr[1] !== 32'h200)
        $display("FAIL same_second act=%h@%h exp=2@200", log_data[1], log_addr[1]); else passed++;
    end
    checks++; if (cpu_rdata !== MEMV) $display("FAIL same_after_drain act=%h exp=%h", cpu_rdata, MEMV); else passed++;
  endtask

  task automatic test_full_stall();
    logic [31:0] exp_a [5];
    logic [31:0] exp_d [5];
    exp_a = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h500};
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h55};
    log_addr.delete(); log_data.delete();
    mem_wack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_we = 1'b1;
      cpu_addr = (i == 2) ? 32'h40B : 32'h400 + 32'(4 * i);
      cpu_wdata = 32'h10 + 32'(i);
      tick();
    end
    cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h55; #1;
    checks++; if (stall !== 1'b1) $display("FAIL full_stall act=%b exp=1", stall); else passed++;
    checks++; if (count !== 3'd4) $display("FAIL full_count act=%0d exp=4", count); else passed++;
    tick(); #1;
    checks++; if (count !== 3'd4) $display("FAIL full_count_hold act=%0d exp=4", count); else passed++;
    mem_wack = 1'b1; #1;
    checks++; if (stall !== 1'b1) $display("FAIL full_stall_with_ack act=%b exp=1", stall); else passed++;
    tick(); #1;
    checks++; if (count !== 3'd3) $display("FAIL full_pop_only act=%0d exp=3", count); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL full_unstall act=%b exp=0", stall); else passed++;
    mem_wack = 1'b0;
    tick();
    cpu_we = 1'b0; #1;
    checks++; if (count !== 3'd4) $display("FAIL full_push_done act=%0d exp=4", count); else passed++;
    checks++; if (cpu_rdata !== 32'h55) $display("FAIL full_fwd_wrapped act=%h exp=55", cpu_rdata); else passed++;
    cpu_addr = 32'h408; #1;
    checks++; if (cpu_rdata !== 32'h12) $display("FAIL full_fwd_offset act=%h exp=12", cpu_rdata); else passed++;
    mem_wack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_wack = 1'b0; #1;
    checks++; if (log_data.size() != 5) $display("FAIL full_nwrites act=%0d exp=5", log_data.size()); else passed++;
    if (log_data.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (log_addr[i] !== exp_a[i] || log_data[i] !== exp_d[i])
          $display("FAIL full_order[%0d] act=%h@%h exp=%h@%h", i, log_data[i], log_addr[i], exp_d[i], exp_a[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    log_addr.delete(); log_data.delete();
    mem_wack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cpu_we = 1'b1; cpu_addr = 32'h600 + 32'(4 * i); cpu_wdata = 32'h100 + 32'(i); #1;
      checks++; if (count !== ((i == 0) ? 3'd0 : 3'd1))
        $display("FAIL b2b_count[%0d] act=%0d exp=%0d", i, count, (i == 0) ? 0 : 1); else passed++;
      tick();
    end
    cpu_we = 1'b0;
    tick();
    mem_wack = 1'b0; #1;
    checks++; if (count !== 3'd0) $display("FAIL b2b_final_count act=%0d exp=0", count); else passed++;
    checks++; if (log_data.size() != 10) $display("FAIL b2b_nwrites act=%0d exp=10", log_data.size()); else passed++;
    if (log_data.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        checks++; if (log_addr[i] !== 32'h600 + 32'(4 * i) || log_data[i] !== 32'h100 + 32'(i))
          $display("FAIL b2b_order[%0d] act=%h@%h exp=%h@%h", i, log_data[i], log_addr[i],
                   32'h100 + 32'(i), 32'h600 + 32'(4 * i));
        else passed++;
      end
    end
  endtask

  task automatic test_ack_when_empty();
    log_addr.delete(); log_data.delete();
    cpu_we = 1'b0; mem_wack = 1'b1;
    tick(); tick(); tick(); #1;
    checks++; if (count !== 3'd0) $display("FAIL idle_ack_count act=%0d exp=0", count); else passed++;
    checks++; if (mem_wreq !== 1'b0) $display("FAIL idle_ack_wreq act=%b exp=0", mem_wreq); else passed++;
    checks++; if (log_data.size() != 0) $display("FAIL idle_ack_writes act=%0d exp=0", log_data.size()); else passed++;
    mem_wack = 1'b0;
    cpu_we = 1'b1; cpu_addr = 32'h700; cpu_wdata = 32'h77; tick();
    cpu_we = 1'b0; #1;
    checks++; if (mem_waddr !== 32'h700 || mem_wdata !== 32'h77)
      $display("FAIL idle_ack_head act=%h@%h exp=77@700", mem_wdata, mem_waddr); else passed++;
    checks++; if (count !== 3'd1) $display("FAIL idle_ack_push act=%0d exp=1", count); else passed++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_drain();
    test_single_store();
    test_same_word();
    test_full_stall();
    test_back_to_back();
    test_ack_when_empty();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
